// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types for the pipeline stall/flush controller
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic if_en;
    logic id_en;
    logic ex_en;
    logic mem_en;
    logic wb_en;
  } stage_en_t;

  localparam stage_en_t STAGE_ALL  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam stage_en_t STAGE_NONE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - request inputs and stage control outputs of pipeline_ctrl
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             hz_stall;
  logic             hz_flush_ex;
  logic             mem_busy;
  logic             fetch_busy;
  logic             br_taken;
  logic             halt_wb;
  logic             if_en;
  logic             id_en;
  logic             ex_en;
  logic             mem_en;
  logic             wb_en;
  logic             flush_id;
  logic             flush_ex;
  logic             redirect;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output hz_stall, hz_flush_ex, mem_busy, fetch_busy, br_taken, halt_wb,
    input  if_en, id_en, ex_en, mem_en, wb_en, flush_id, flush_ex, redirect, halted,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  hz_stall, hz_flush_ex, mem_busy, fetch_busy, br_taken, halt_wb,
    output if_en, id_en, ex_en, mem_en, wb_en, flush_id, flush_ex, redirect, halted,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// rtl/pipeline_ctrl_sat_counter.sv - saturating event counter with synchronous clear
module pipeline_ctrl_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt = r_cnt;
endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stage advance enables, bubble/flush strobes and redirect sequencing
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.slave bus
);
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  ctrl_state_t r_state;
  logic [FW-1:0] r_fcnt;
  logic          r_br_pend;

  stage_en_t w_en;
  logic      w_flush_id;
  logic      w_flush_ex;
  logic      w_redirect;
  logic      w_halted;
  logic      w_br_req;
  logic      w_stall_inc;

  assign w_br_req = bus.br_taken | r_br_pend;

  always_comb begin
    w_en       = STAGE_NONE;
    w_flush_id = 1'b0;
    w_flush_ex = 1'b0;
    w_redirect = 1'b0;
    w_halted   = 1'b0;
    if (rst) begin
      w_flush_id = 1'b1;
      w_flush_ex = 1'b1;
    end else if (r_state == HALTED) begin
      w_halted = 1'b1;
    end else if (bus.mem_busy) begin
      w_en = STAGE_NONE;
    end else if (w_br_req) begin
      // Younger ops behind the branch are dead, so a concurrent load-use stall is moot.
      w_en       = STAGE_ALL;
      w_redirect = 1'b1;
      w_flush_id = 1'b1;
    end else if (bus.hz_stall) begin
      w_en       = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      w_flush_ex = bus.hz_flush_ex;
    end else if (bus.fetch_busy || (r_state == FLUSH)) begin
      w_en       = STAGE_ALL;
      w_flush_id = 1'b1;
    end else begin
      w_en = STAGE_ALL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RUN;
      r_fcnt    <= '0;
      r_br_pend <= 1'b0;
    end else if (r_state != HALTED) begin
      if (bus.mem_busy) begin
        if (bus.br_taken) r_br_pend <= 1'b1;
      end else if (bus.halt_wb) begin
        r_state   <= HALTED;
        r_br_pend <= 1'b0;
      end else if (w_br_req) begin
        r_state   <= FLUSH;
        r_fcnt    <= FW'(FLUSH_CYCLES - 1);
        r_br_pend <= 1'b0;
      end else if (r_state == FLUSH) begin
        if (r_fcnt == '0) r_state <= RUN;
        else              r_fcnt  <= r_fcnt - FW'(1);
      end
    end
  end

  assign w_stall_inc = !rst && (r_state != HALTED) && !w_en.id_en;

  pipeline_ctrl_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (w_stall_inc),
    .cnt (bus.stall_cnt)
  );

  pipeline_ctrl_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (rst),
    .inc (w_redirect),
    .cnt (bus.flush_cnt)
  );

  assign bus.if_en    = w_en.if_en;
  assign bus.id_en    = w_en.id_en;
  assign bus.ex_en    = w_en.ex_en;
  assign bus.mem_en   = w_en.mem_en;
  assign bus.wb_en    = w_en.wb_en;
  assign bus.flush_id = w_flush_id;
  assign bus.flush_ex = w_flush_ex;
  assign bus.redirect = w_redirect;
  assign bus.halted   = w_halted;
endmodule
